// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parametrised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int AE_THRESH_DEF = 2;
    localparam int AF_MARGIN_DEF = 2;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered or first-word-fall-through
// read, programmable almost flags, fill level and sticky error flags.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - AF_MARGIN_DEF,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wren,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         rden,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [ptr_width(DEPTH):0]    level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = PW + 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    if (!(DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0 &&
          AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_param_check
        $fatal(1, "fifo_param: DEPTH must be a power of two >= 2 and 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [LW-1:0]         count;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  mem_we;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_L);
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);
    assign level        = count;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_ok  = rden & ~empty;
    assign wr_ok  = wren & (~full | rd_ok);
    assign mem_we = wr_ok & ~rst & ~clr;

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr),
        .wdata (i_data),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            dout_q <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_ok) begin
                rptr   <= rptr + PW'(1);
                dout_q <= rdata;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + LW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - LW'(1);
            end
            if (wren && !wr_ok) begin
                ovf_q <= 1'b1;
            end
            if (rden && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    // Fall-through presents the head entry directly; zero while empty.
    assign o_data = (MODE == FIFO_FWFT) ? (empty ? '0 : rdata) : dout_q;

endmodule
